// File: rtl/prog_counter.sv
// Parametrised registered program/address counter with step, up/down, load,
// synchronous clear, wrap or saturate mode and overflow/terminal flags.
module prog_counter #(
  parameter int unsigned      WIDTH     = 16,
  parameter int unsigned      STEP      = 1,
  parameter bit               SATURATE  = 1'b0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] out,
  output logic             ovf,
  output logic             at_max,
  output logic             at_min
);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("prog_counter: WIDTH must be in 2..32");
  end
  if (STEP == 0 || 64'(STEP) >= (64'd1 << WIDTH)) begin : g_bad_step
    $error("prog_counter: STEP must be in 1..2^WIDTH-1");
  end

  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  logic [WIDTH-1:0] operand_b;
  logic [WIDTH-1:0] chain_sum;
  logic [WIDTH:0]   carry;
  logic             wrapped;
  logic [WIDTH-1:0] nxt_out;
  logic             nxt_ovf;

  // Decrement reuses the adder as out + ~STEP + 1; carry-out then means "no borrow".
  assign operand_b = dec ? ~STEP_W : STEP_W;
  assign carry[0]  = dec;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign chain_sum[i] = out[i] ^ operand_b[i] ^ carry[i];
    assign carry[i+1]   = (out[i] & operand_b[i]) | (carry[i] & (out[i] ^ operand_b[i]));
  end

  assign wrapped = inc ? carry[WIDTH] : ~carry[WIDTH];

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    nxt_out = out;
    nxt_ovf = 1'b0;
    if (clr) begin
      nxt_out = RESET_VAL;
    end else if (load) begin
      nxt_out = load_val;
    end else if (inc ^ dec) begin
      nxt_out = chain_sum;
      if (wrapped) begin
        nxt_ovf = 1'b1;
        if (SATURATE) begin
          nxt_out = inc ? '1 : '0;
        end
      end
    end
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out <= RESET_VAL;
      ovf <= 1'b0;
    end else begin
      out <= nxt_out;
      ovf <= nxt_ovf;
    end
  end

  assign at_max = &out;
  assign at_min = ~|out;

endmodule
